// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button / switch debouncer and any lab
// block that needs to interpret its state encoding.
package debounce_pkg;

    // Default qualification length: 1 ms of stable input at 50 MHz.
    localparam int DEFAULT_STABLE_COUNT = 50000;

    // Default counter width; must hold DEFAULT_STABLE_COUNT - 1.
    localparam int DEFAULT_CNT_WIDTH = 16;

    // Debouncer FSM states. The encoding is fixed so that the state can be
    // probed directly when the block is wired into other experiments.
    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b10,
        S_WAIT_LOW  = 2'b11
    } db_state_t;

    // Level currently presented on db_out while the FSM sits in a state.
    // A WAIT state keeps showing the previously accepted level.
    function automatic logic state_level(input db_state_t s);
        return (s == S_HIGH) || (s == S_WAIT_LOW);
    endfunction

    // True for the two states in which a new level is being qualified.
    function automatic logic state_is_wait(input db_state_t s);
        return (s == S_WAIT_HIGH) || (s == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk
// domain. Reusable by any lab block with raw switch or button inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for a bouncing push-button or slide switch: synchronizes the raw
// input, requires STABLE_COUNT consecutive samples of a new level before
// accepting it, and emits one-cycle rise/fall pulses on each acceptance.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    // Counter value on the sample that completes qualification.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync2;
    db_state_t            state;
    db_state_t            state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 db_next;
    logic                 rise_next;
    logic                 fall_next;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (sync2)
    );

    // Next-state, counter and output decisions; the counter is zero unless a
    // WAIT state is explicitly advancing it, so every state exit clears it.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        db_next    = db_out;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            S_LOW: begin
                if (sync2) begin
                    state_next = S_WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync2) begin
                    state_next = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_HIGH;
                    db_next    = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync2) begin
                    state_next = S_WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            S_WAIT_LOW: begin
                if (sync2) begin
                    state_next = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_LOW;
                    db_next    = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                db_next    = 1'b0;
            end
        endcase
    end

    // State, counter and all outputs are registered together so db_out and
    // the pulses come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LOW;
            cnt        <= '0;
            db_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            db_out     <= db_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_COUNT=4, CNT_WIDTH=4.
// Each applyStimulus call drives btn_in just after a rising edge, so the
// following edge samples it into sync1; that edge is call n, the FSM sees it
// at call n+2, and a held level is accepted at call n+5.
module tb_button_debouncer;
    import debounce_pkg::*;

    localparam int SC = 4;
    localparam int CW = 4;

    logic clk;
    logic reset;
    logic btn_in;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;

    int totalChecks  = 0;
    int passedChecks = 0;

    button_debouncer #(
        .STABLE_COUNT (SC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got === exp) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks the three outputs against expected values.
    task automatic checkAll(input string tag, input logic expDb, input logic expRise, input logic expFall);
        checkOutput({tag, ".db_out"}, 32'(db_out), 32'(expDb));
        checkOutput({tag, ".rise"}, 32'(rise_pulse), 32'(expRise));
        checkOutput({tag, ".fall"}, 32'(fall_pulse), 32'(expFall));
    endtask

    // Drives btn_in, waits for the next rising edge and settles 1 time unit.
    task automatic applyStimulus(input logic b);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    logic bouncePat [0:11];

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.state", 32'(dut.state), 32'(S_LOW));
        checkOutput("reset.cnt", 32'(dut.cnt), 32'd0);
        reset = 1'b0;

        // Clean press: accepted on call 6, pulse gone on call 7.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1);
            checkAll($sformatf("press%0d", i), i >= 6, i == 6, 1'b0);
        end

        // Release: fall pulse on call 6 only, no rise.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0);
            checkAll($sformatf("release%0d", i), i < 6, 1'b0, i == 6);
        end

        // Glitch: three high samples reach the FSM, one short of acceptance.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(i <= 3);
            checkAll($sformatf("glitch%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Bounce 1,0,1,1,0 then hold 1 from call 6: single rise on call 11.
        bouncePat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(bouncePat[i-1]);
            checkAll($sformatf("bounce%0d", i), i >= 11, i == 11, 1'b0);
        end

        // Return to low before the reset scenarios.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0);
        end
        checkAll("idle", 1'b0, 1'b0, 1'b0);

        // Reset mid-WAIT: reach S_WAIT_HIGH with cnt=2, then reset between edges.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1);
        end
        checkOutput("midwait.state", 32'(dut.state), 32'(S_WAIT_HIGH));
        checkOutput("midwait.cnt", 32'(dut.cnt), 32'd2);
        reset = 1'b1;
        #1;
        checkAll("asyncrst", 1'b0, 1'b0, 1'b0);
        checkOutput("asyncrst.state", 32'(dut.state), 32'(S_LOW));
        checkOutput("asyncrst.cnt", 32'(dut.cnt), 32'd0);
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1);
            checkAll($sformatf("requal%0d", i), i >= 6, i == 6, 1'b0);
        end

        // Reset while high: db_out drops with no fall pulse.
        btn_in = 1'b0;
        reset  = 1'b1;
        #1;
        checkAll("rsthigh", 1'b0, 1'b0, 1'b0);
        checkOutput("rsthigh.state", 32'(dut.state), 32'(S_LOW));
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0);
            checkAll($sformatf("postrst%0d", i), 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
